enc_dec_core: RTL and testbench

- Sequential extended-Hamming (SECDED) encode/decode engine.
- Sits directly downstream of the APB register bank: consumes CTRL, DATA_IN, CODEWORD_WIDTH and NOISE plus a start pulse.
- Produces the DATA_OUT word, the 2-bit number_of_errors result and the operation_done pulse that the golden model and the register bank observe.
- Supports 8-, 16- and 32-bit codewords and three modes: encode, decode, and full channel (encode, then XOR with noise, then decode).

---
 rtl/enc_dec_core.sv | 187 ++++++++++++++++++
 tb/tb_enc_dec_core.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/enc_dec_core.sv
// Sequential extended-Hamming (SECDED) encode/decode engine for 8/16/32-bit codewords.
// One request at a time: capture, encode and/or decode, then a single-cycle done pulse.
module enc_dec_core #(
    parameter int AMBA_WORD = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           ctrl,
    input  logic [AMBA_WORD-1:0] data_in,
    input  logic [1:0]           codeword_width,
    input  logic [AMBA_WORD-1:0] noise,
    output logic [AMBA_WORD-1:0] data_out,
    output logic [1:0]           num_of_errors,
    output logic                 operation_done,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ENC  = 2'b01,
        DEC  = 2'b10,
        DONE = 2'b11
    } state_t;

    // Column value of data bit i: the i-th integer >= 3 that is not a power of two.
    // The list is prefix-consistent, so the 8- and 16-bit codes use its first 4 / 11 entries.
    localparam logic [4:0] COL [26] = '{
        5'd3,  5'd5,  5'd6,  5'd7,  5'd9,  5'd10, 5'd11, 5'd12, 5'd13,
        5'd14, 5'd15, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd22, 5'd23,
        5'd24, 5'd25, 5'd26, 5'd27, 5'd28, 5'd29, 5'd30, 5'd31
    };

    // XOR of the column values of all set data bits equals the vector of parity bits.
    function automatic logic [4:0] calc_parity(input logic [25:0] d);
        logic [4:0] par;
        par = '0;
        for (int i = 0; i < 26; i++) begin
            if (d[i]) par = par ^ COL[i];
        end
        return par;
    endfunction

    function automatic logic [25:0] data_mask(input logic [1:0] w);
        logic [25:0] m;
        case (w)
            2'b00:   m = 26'h000_000F;
            2'b01:   m = 26'h000_07FF;
            default: m = 26'h3FF_FFFF;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] width_mask(input logic [1:0] w);
        logic [31:0] m;
        case (w)
            2'b00:   m = 32'h0000_00FF;
            2'b01:   m = 32'h0000_FFFF;
            default: m = 32'hFFFF_FFFF;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] encode(input logic [25:0] d, input logic [1:0] w);
        logic [25:0] dm;
        logic [4:0]  par;
        logic [31:0] cw;
        dm  = d & data_mask(w);
        par = calc_parity(dm);
        case (w)
            2'b00:   cw = {24'b0, ^{dm[3:0], par[2:0]}, par[2:0], dm[3:0]};
            2'b01:   cw = {16'b0, ^{dm[10:0], par[3:0]}, par[3:0], dm[10:0]};
            default: cw = {^{dm, par}, par, dm};
        endcase
        return cw;
    endfunction

    // Returns {errors, zero-extended data}. Bits above the codeword width are ignored.
    function automatic logic [33:0] decode(input logic [31:0] r, input logic [1:0] w);
        logic [25:0] dat;
        logic [4:0]  rp;
        logic [4:0]  syn;
        logic        ov;
        logic [1:0]  err;
        case (w)
            2'b00: begin
                dat = {22'b0, r[3:0]};
                rp  = {2'b0, r[6:4]};
                ov  = ^r[7:0];
            end
            2'b01: begin
                dat = {15'b0, r[10:0]};
                rp  = {1'b0, r[14:11]};
                ov  = ^r[15:0];
            end
            default: begin
                dat = r[25:0];
                rp  = r[30:26];
                ov  = ^r;
            end
        endcase
        syn = calc_parity(dat) ^ rp;
        if (ov) begin
            // Syndromes of zero or a power of two point at parity bits; no column matches them.
            err = 2'b01;
            for (int i = 0; i < 26; i++) begin
                if (COL[i] == syn) dat[i] = ~dat[i];
            end
        end else if (syn != 5'd0) begin
            err = 2'b10;
        end else begin
            err = 2'b00;
        end
        return {err, 6'b0, dat};
    endfunction

    state_t      state;
    logic [1:0]  ctrl_q;
    logic [1:0]  width_q;
    logic [31:0] data_q;
    logic [31:0] noise_q;
    logic [31:0] cw_p0;

    logic [31:0] enc_cw;
    logic [31:0] dec_src;
    logic [33:0] dec_res;

    assign enc_cw  = encode(data_q[25:0], width_q);
    assign dec_src = (ctrl_q == 2'b10) ? cw_p0 : data_q;
    assign dec_res = decode(dec_src, width_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            ctrl_q         <= '0;
            width_q        <= '0;
            data_q         <= '0;
            noise_q        <= '0;
            cw_p0          <= '0;
            data_out       <= '0;
            num_of_errors  <= '0;
            operation_done <= 1'b0;
            busy           <= 1'b0;
        end else begin
            operation_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        ctrl_q  <= ctrl;
                        width_q <= codeword_width;
                        data_q  <= data_in;
                        noise_q <= noise;
                        busy    <= 1'b1;
                        state   <= (ctrl == 2'b00 || ctrl == 2'b10) ? ENC : DEC;
                    end
                end
                // Encode stage: either finish here or feed the noisy codeword to decode.
                ENC: begin
                    if (ctrl_q == 2'b10) begin
                        cw_p0 <= enc_cw ^ (noise_q & width_mask(width_q));
                        state <= DEC;
                    end else begin
                        data_out       <= enc_cw;
                        num_of_errors  <= 2'b00;
                        operation_done <= 1'b1;
                        state          <= DONE;
                    end
                end
                // Decode stage: result registers load on entry to DONE.
                DEC: begin
                    data_out       <= dec_res[31:0];
                    num_of_errors  <= dec_res[33:32];
                    operation_done <= 1'b1;
                    state          <= DONE;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_enc_dec_core.sv
// Randomized and directed bench for enc_dec_core against a cycle-level reference model
// built from the SECDED code rules (column values, parity and syndrome arithmetic).
module tb_enc_dec_core;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  ctrl = 2'b00;
    logic [31:0] data_in = '0;
    logic [1:0]  codeword_width = 2'b00;
    logic [31:0] noise = '0;
    logic [31:0] data_out;
    logic [1:0]  num_of_errors;
    logic        operation_done;
    logic        busy;

    enc_dec_core #(.AMBA_WORD(32)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .ctrl(ctrl),
        .data_in(data_in),
        .codeword_width(codeword_width),
        .noise(noise),
        .data_out(data_out),
        .num_of_errors(num_of_errors),
        .operation_done(operation_done),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- code model ----------------
    function automatic int w2n(input logic [1:0] w);
        return (w == 2'b00) ? 8 : (w == 2'b01) ? 16 : 32;
    endfunction

    function automatic int n2p(input int n);
        return (n == 8) ? 4 : (n == 16) ? 5 : 6;
    endfunction

    function automatic int col(input int idx);
        int cnt;
        cnt = 0;
        for (int v = 3; v < 64; v++) begin
            if ((v & (v - 1)) != 0) begin
                if (cnt == idx) return v;
                cnt++;
            end
        end
        return 0;
    endfunction

    function automatic logic [31:0] nmask(input int n);
        return (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
    endfunction

    function automatic logic [31:0] m_encode(input logic [31:0] d, input logic [1:0] w);
        int n, p, k, par;
        logic [31:0] cw;
        n = w2n(w); p = n2p(n); k = n - p; cw = '0;
        for (int i = 0; i < k; i++) cw[i] = d[i];
        for (int j = 0; j < p - 1; j++) begin
            par = 0;
            for (int i = 0; i < k; i++)
                if (((col(i) >> j) & 1) == 1) par = par ^ int'(d[i]);
            cw[k + j] = par[0];
        end
        cw[n - 1] = ^cw;
        return cw;
    endfunction

    function automatic void m_decode(input logic [31:0] rin, input logic [1:0] w,
                                     output logic [31:0] dat, output logic [1:0] err);
        int n, p, k, par, s;
        logic [31:0] r;
        n = w2n(w); p = n2p(n); k = n - p;
        r = rin & nmask(n);
        dat = '0;
        for (int i = 0; i < k; i++) dat[i] = r[i];
        s = 0;
        for (int j = 0; j < p - 1; j++) begin
            par = int'(r[k + j]);
            for (int i = 0; i < k; i++)
                if (((col(i) >> j) & 1) == 1) par = par ^ int'(r[i]);
            s = s | ((par & 1) << j);
        end
        if (^r) begin
            err = 2'd1;
            for (int i = 0; i < k; i++) if (col(i) == s) dat[i] = ~dat[i];
        end else if (s != 0) begin
            err = 2'd2;
        end else begin
            err = 2'd0;
        end
    endfunction

    // ---------------- cycle-level expectation ----------------
    logic [31:0] m_data = '0;
    logic [1:0]  m_err = '0;
    logic        m_done = 1'b0;
    logic        m_busy = 1'b0;
    int          m_cnt = 0;
    logic [1:0]  cap_ctrl, cap_w;
    logic [31:0] cap_d, cap_n;

    initial begin
        logic was_busy, was_done;
        forever begin
            @(posedge clk);
            if (!rst) begin
                m_data = '0; m_err = '0; m_done = 1'b0; m_busy = 1'b0; m_cnt = 0;
            end else begin
                was_busy = m_busy;
                was_done = m_done;
                m_done = 1'b0;
                if (was_done) begin
                    m_busy = 1'b0;
                end else if (m_cnt > 0) begin
                    m_cnt--;
                    if (m_cnt == 0) begin
                        m_done = 1'b1;
                        if (cap_ctrl == 2'b00) begin
                            m_data = m_encode(cap_d, cap_w);
                            m_err  = 2'd0;
                        end else if (cap_ctrl == 2'b10) begin
                            m_decode(m_encode(cap_d, cap_w) ^ (cap_n & nmask(w2n(cap_w))),
                                     cap_w, m_data, m_err);
                        end else begin
                            m_decode(cap_d, cap_w, m_data, m_err);
                        end
                    end
                end
                if (!was_busy && start) begin
                    cap_ctrl = ctrl; cap_w = codeword_width; cap_d = data_in; cap_n = noise;
                    m_busy = 1'b1;
                    m_cnt  = (ctrl == 2'b10) ? 2 : 1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of all outputs against the model.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            check("data_out", data_out, m_data);
            check("num_of_errors", 32'(num_of_errors), 32'(m_err));
            check("operation_done", 32'(operation_done), 32'(m_done));
            check("busy", 32'(busy), 32'(m_busy));
        end
    end

    task automatic run_op(input logic [1:0] c, input logic [1:0] w, input logic [31:0] d,
                          input logic [31:0] nz, input bit second_start, output int lat);
        @(negedge clk);
        ctrl = c; codeword_width = w; data_in = d; noise = nz; start = 1'b1;
        lat = -1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (operation_done) begin
                lat = k;
                break;
            end
            start = second_start && (k == 1);
            data_in = $urandom; noise = $urandom;
            ctrl = 2'($urandom_range(0, 3)); codeword_width = 2'($urandom_range(0, 3));
        end
        start = 1'b0;
        if (lat < 0) begin
            n_cmp++; n_bad++;
            $display("FAIL op_timeout: got no operation_done expected one within 8 cycles");
        end
    endtask

    task automatic directed(input string name, input logic [1:0] c, input logic [1:0] w,
                            input logic [31:0] d, input logic [31:0] nz,
                            input logic [31:0] exp_data, input logic [1:0] exp_err);
        int lat;
        run_op(c, w, d, nz, 1'b0, lat);
        check({name, "_data"}, data_out, exp_data);
        check({name, "_err"}, 32'(num_of_errors), 32'(exp_err));
        check({name, "_latency"}, 32'(lat), (c == 2'b10) ? 32'd3 : 32'd2);
    endtask

    initial begin
        logic [31:0] md;
        logic [1:0]  me;
        int lat, n, k, other, seen;
        logic [31:0] d, nz;

        // Model pins from hand-worked N=8 examples.
        check("model_enc_b", m_encode(32'hB, 2'b00), 32'h1B);
        m_decode(32'h1A, 2'b00, md, me);
        check("model_dec_1a_data", md, 32'hB);
        check("model_dec_1a_err", 32'(me), 32'd1);
        m_decode(32'h18, 2'b00, md, me);
        check("model_dec_18_data", md, 32'h8);
        check("model_dec_18_err", 32'(me), 32'd2);

        repeat (3) @(negedge clk);
        check("reset_data_out", data_out, 32'h0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(operation_done), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        directed("enc_b", 2'b00, 2'b00, 32'h0000_000B, 32'h0, 32'h1B, 2'd0);
        directed("enc_b_hibits", 2'b00, 2'b00, 32'hFFFF_FFFB, 32'h0, 32'h1B, 2'd0);
        directed("dec_1b", 2'b01, 2'b00, 32'h1B, 32'h0, 32'hB, 2'd0);
        directed("dec_9b", 2'b01, 2'b00, 32'h9B, 32'h0, 32'hB, 2'd1);
        directed("dec_1b_hibits", 2'b11, 2'b00, 32'hABCD_E01B, 32'h0, 32'hB, 2'd0);
        directed("full_n01", 2'b10, 2'b00, 32'hB, 32'h01, 32'hB, 2'd1);
        directed("full_n03", 2'b10, 2'b00, 32'hB, 32'h03, 32'h8, 2'd2);

        // Noise weight 0/1/2 sweep over every bit position for N=16 and N=32.
        for (int wi = 1; wi <= 2; wi++) begin
            n = w2n(2'(wi)); k = n - n2p(n);
            for (int r = 0; r < 4; r++) begin
                d = $urandom;
                run_op(2'b10, 2'(wi), d, 32'h0, 1'b0, lat);
                check("sweep_w0_data", data_out, d & nmask(k));
                check("sweep_w0_err", 32'(num_of_errors), 32'd0);
            end
            for (int pos = 0; pos < n; pos++) begin
                d = $urandom;
                nz = (32'd1 << pos) | ($urandom & ~nmask(n));
                run_op(2'b10, 2'(wi), d, nz, 1'b0, lat);
                check("sweep_w1_data", data_out, d & nmask(k));
                check("sweep_w1_err", 32'(num_of_errors), 32'd1);
            end
            for (int pos = 0; pos < n; pos++) begin
                d = $urandom;
                other = (pos + 1 + $urandom_range(0, n - 2)) % n;
                nz = (32'd1 << pos) | (32'd1 << other);
                run_op(2'b10, 2'(wi), d, nz, 1'b0, lat);
                check("sweep_w2_err", 32'(num_of_errors), 32'd2);
            end
        end

        // Random mix of modes and widths, decode inputs built from valid codewords plus noise.
        for (int r = 0; r < 60; r++) begin
            logic [1:0] c, w;
            c = 2'($urandom_range(0, 3));
            w = 2'($urandom_range(0, 3));
            d = $urandom;
            nz = '0;
            for (int b = 0; b < int'($urandom_range(0, 3)); b++) nz[$urandom_range(0, 31)] = 1'b1;
            if (c == 2'b01 || c == 2'b11) d = m_encode(d, w) ^ nz ^ ($urandom & ~nmask(w2n(w)));
            run_op(c, w, d, nz, 1'b0, lat);
            check("random_latency", 32'(lat), (c == 2'b10) ? 32'd3 : 32'd2);
        end

        // A second start while busy is ignored: one done pulse, result from the first request.
        run_op(2'b00, 2'b01, 32'h0000_0555, 32'h0, 1'b1, lat);
        check("busy_start_data", data_out, m_encode(32'h555, 2'b01));
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (operation_done) seen++;
        end
        check("busy_start_extra_done", 32'(seen), 32'd0);
        check("busy_start_idle", 32'(busy), 32'd0);

        // Reset during ENC aborts the operation.
        @(negedge clk);
        ctrl = 2'b10; codeword_width = 2'b10; data_in = 32'h1234_5678; noise = 32'h10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("abort_data_out", data_out, 32'h0);
        check("abort_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (operation_done) seen++;
        end
        check("abort_no_done", 32'(seen), 32'd0);
        directed("after_abort", 2'b10, 2'b00, 32'hB, 32'h01, 32'hB, 2'd1);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test expected completion before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
